tx_frame_scheduler: RTL and testbench

- Sequences the UART TX datapath by arbitrating between two requesters and feeding it one byte per frame.
  - Channel 0: 8-bit register-file read data.
  - Channel 1: 16-bit ALU result, sent as two frames.
- Issues single-cycle data-valid pulses and tracks the transmitter's busy flag to know when each frame completes.
- Sits between the system controller datapath and the UART TX top.

---
 rtl/tx_frame_scheduler.sv | 88 ++++++++
 tb/tb_tx_frame_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: round-robin arbiter feeding 8-bit reg-file bytes or 16-bit ALU words
// (low byte first) to the UART TX one frame at a time, tracking tx_busy per frame.
module tx_frame_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int BUSY_WAIT_MAX = 15,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    ch0_req,
    input  logic [DATA_WIDTH-1:0]   ch0_data,
    output logic                    ch0_ack,
    input  logic                    ch1_req,
    input  logic [2*DATA_WIDTH-1:0] ch1_data,
    output logic                    ch1_ack,
    input  logic                    tx_busy,
    output logic                    tx_data_valid,
    output logic [DATA_WIDTH-1:0]   tx_p_data,
    output logic                    sched_busy,
    output logic                    err_timeout
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
    state_t                  state;
    logic [2*DATA_WIDTH-1:0] data_buf;
    logic [1:0]              bytes_left;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    rr;
    logic                    grant1;
    // rr=1 means ch1 wins a contended grant
    assign grant1     = ch1_req && (!ch0_req || rr);
    assign sched_busy = state != IDLE;
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            data_buf      <= '0;
            bytes_left    <= '0;
            cnt           <= '0;
            rr            <= 1'b0;
            ch0_ack       <= 1'b0;
            ch1_ack       <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= '0;
            err_timeout   <= 1'b0;
        end else begin
            ch0_ack       <= 1'b0;
            ch1_ack       <= 1'b0;
            tx_data_valid <= 1'b0;
            err_timeout   <= 1'b0;
            case (state)
                IDLE: if (!tx_busy && (ch0_req || ch1_req)) begin
                    if (ch0_req && ch1_req) rr <= ~rr;
                    ch0_ack       <= !grant1;
                    ch1_ack       <= grant1;
                    data_buf      <= grant1 ? ch1_data : {{DATA_WIDTH{1'b0}}, ch0_data};
                    tx_p_data     <= grant1 ? ch1_data[DATA_WIDTH-1:0] : ch0_data;
                    bytes_left    <= grant1 ? 2'd2 : 2'd1;
                    tx_data_valid <= 1'b1;
                    state         <= SEND;
                end
                SEND: begin
                    cnt   <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: if (tx_busy) begin
                    state <= WAIT_LO;
                end else begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(BUSY_WAIT_MAX - 1)) begin
                        err_timeout <= 1'b1;
                        bytes_left  <= '0;
                        state       <= IDLE;
                    end
                end
                WAIT_LO: if (!tx_busy) begin
                    bytes_left <= bytes_left - 2'd1;
                    if (bytes_left == 2'd2) begin
                        tx_p_data     <= data_buf[2*DATA_WIDTH-1:DATA_WIDTH];
                        tx_data_valid <= 1'b1;
                        state         <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: directed requests with a queued scoreboard checked by a negedge monitor,
// plus a behavioural UART TX busy model.
module tb_tx_frame_scheduler;
    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        ch0_req = 1'b0, ch1_req = 1'b0;
    logic [7:0]  ch0_data = '0;
    logic [15:0] ch1_data = '0;
    logic        ch0_ack, ch1_ack, tx_data_valid, sched_busy, err_timeout;
    logic [7:0]  tx_p_data;
    logic        model_busy = 1'b0, ext_busy = 1'b0, model_off = 1'b0;
    logic        tx_busy;
    logic        prev_dv = 1'b0;
    int          n_chk = 0, n_fail = 0;
    int          mcnt = 0;
    time         t_dv = 0, t_fall = 0;
    logic [7:0]  exp_byte[$];
    int          exp_ack[$];
    int          exp_err[$];

    assign tx_busy = model_busy | ext_busy;

    tx_frame_scheduler #(.DATA_WIDTH(8), .BUSY_WAIT_MAX(15), .CNT_WIDTH(4)) dut (
        .CLK(CLK), .rst(rst),
        .ch0_req(ch0_req), .ch0_data(ch0_data), .ch0_ack(ch0_ack),
        .ch1_req(ch1_req), .ch1_data(ch1_data), .ch1_ack(ch1_ack),
        .tx_busy(tx_busy), .tx_data_valid(tx_data_valid), .tx_p_data(tx_p_data),
        .sched_busy(sched_busy), .err_timeout(err_timeout)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART TX model: busy rises one cycle after a pulse and holds for 10 cycles
    initial forever begin
        @(negedge CLK);
        if (!rst) begin
            mcnt = 0;
            model_busy = 1'b0;
        end else begin
            if (tx_data_valid) chk("dv_while_busy", 32'(tx_busy), 0);
            if (mcnt > 0) begin
                model_busy = 1'b1;
                mcnt--;
            end else begin
                if (model_busy) t_fall = $time;
                model_busy = 1'b0;
            end
            if (tx_data_valid && !model_off) mcnt = 10;
        end
    end

    initial forever begin
        @(negedge CLK);
        if (tx_data_valid) begin
            chk("dv_gap", 32'(prev_dv), 0);
            chk("dv_expected", 32'(exp_byte.size() > 0), 1);
            if (exp_byte.size() > 0) chk("tx_p_data", 32'(tx_p_data), 32'(exp_byte.pop_front()));
            t_dv = $time;
        end
        prev_dv = tx_data_valid;
        if (ch0_ack || ch1_ack) begin
            chk("ack_with_dv", 32'(tx_data_valid), 1);
            chk("ack_expected", 32'(exp_ack.size() > 0), 1);
            if (exp_ack.size() > 0) chk("ack_channel", 32'({ch1_ack, ch0_ack}), 32'(exp_ack.pop_front()));
        end
        if (err_timeout) begin
            chk("err_expected", 32'(exp_err.size() > 0), 1);
            if (exp_err.size() > 0) chk("err_delay", 32'(($time - t_dv) / 10), 32'(exp_err.pop_front()));
        end
    end

    task automatic run(input logic r0, input logic [7:0] d0, input logic r1, input logic [15:0] d1);
        ch0_data = d0;
        ch1_data = d1;
        ch0_req  = r0;
        ch1_req  = r1;
        for (int i = 0; i < 400 && (ch0_req || ch1_req); i++) begin
            @(negedge CLK);
            if (ch0_ack) ch0_req = 1'b0;
            if (ch1_ack) ch1_req = 1'b0;
        end
        chk("req_acked", 32'({ch0_req, ch1_req}), 0);
        ch0_req = 1'b0;
        ch1_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (!sched_busy && !tx_busy && exp_byte.size() == 0 && exp_err.size() == 0) break;
        end
        chk("idle_reached", 32'(sched_busy), 0);
        chk("queue_drained", 32'(exp_byte.size() + exp_ack.size() + exp_err.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1);
    end

    initial begin
        @(negedge CLK);
        chk("reset_outs", 32'({ch0_ack, ch1_ack, tx_data_valid, sched_busy, err_timeout}), 0);
        chk("reset_pdata", 32'(tx_p_data), 0);
        rst = 1'b1;
        @(negedge CLK);
        exp_ack.push_back(1); exp_byte.push_back(8'hA5);
        run(1'b1, 8'hA5, 1'b0, 16'h0);
        for (int i = 0; i < 50 && sched_busy; i++) @(negedge CLK);
        chk("sched_fall", 32'(($time - t_fall) / 10), 1);
        wait_idle();
        chk("hold_idle", 32'(tx_p_data), 32'h A5);
        exp_ack.push_back(2); exp_byte.push_back(8'h34); exp_byte.push_back(8'h12);
        run(1'b0, 8'h0, 1'b1, 16'h1234);
        wait_idle();
        exp_ack.push_back(1); exp_byte.push_back(8'h11);
        exp_ack.push_back(2); exp_byte.push_back(8'hEF); exp_byte.push_back(8'hBE);
        run(1'b1, 8'h11, 1'b1, 16'hBEEF);
        wait_idle();
        exp_ack.push_back(2); exp_byte.push_back(8'hDE); exp_byte.push_back(8'hC0);
        exp_ack.push_back(1); exp_byte.push_back(8'h22);
        run(1'b1, 8'h22, 1'b1, 16'hC0DE);
        wait_idle();
        model_off = 1'b1;
        exp_ack.push_back(2); exp_byte.push_back(8'h66); exp_err.push_back(16);
        run(1'b0, 8'h0, 1'b1, 16'h5566);
        for (int i = 0; i < 40 && !err_timeout; i++) @(negedge CLK);
        chk("err_seen", 32'(err_timeout), 1);
        chk("idle_after_err", 32'(sched_busy), 0);
        repeat (20) @(negedge CLK);
        model_off = 1'b0;
        wait_idle();
        ext_busy = 1'b1;
        exp_ack.push_back(1); exp_byte.push_back(8'h3C);
        ch0_data = 8'h3C;
        ch0_req  = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            chk("no_ack_busy", 32'(ch0_ack), 0);
        end
        ext_busy = 1'b0;
        @(negedge CLK);
        chk("ack_after_busy", 32'(ch0_ack), 1);
        ch0_req = 1'b0;
        wait_idle();
        exp_ack.push_back(1); exp_byte.push_back(8'h5A);
        exp_ack.push_back(2); exp_byte.push_back(8'hFE);
        run(1'b1, 8'h5A, 1'b1, 16'hCAFE);
        repeat (4) @(negedge CLK);
        chk("in_wait_lo", 32'({sched_busy, tx_busy}), 32'h3);
        #1 rst = 1'b0;
        #1;
        chk("rst_outs", 32'({ch0_ack, ch1_ack, tx_data_valid, sched_busy, err_timeout}), 0);
        chk("rst_pdata", 32'(tx_p_data), 0);
        repeat (2) @(negedge CLK);
        rst = 1'b1;
        chk("rst_queue", 32'(exp_byte.size() + exp_ack.size()), 0);
        exp_ack.push_back(2); exp_byte.push_back(8'hFE); exp_byte.push_back(8'hCA);
        run(1'b0, 8'h0, 1'b1, 16'hCAFE);
        wait_idle();
        exp_ack.push_back(1); exp_byte.push_back(8'h77);
        exp_ack.push_back(2); exp_byte.push_back(8'h57); exp_byte.push_back(8'h13);
        run(1'b1, 8'h77, 1'b1, 16'h1357);
        wait_idle();
        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
